// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Request/acknowledge bus between the MEM-stage controller and
//               a variable-latency data memory.
//               master modport : controller side (drives request fields)
//               slave modport  : memory side (drives ack and read data)
//               Signals: mem_req, mem_we, mem_be[3:0], mem_addr[ADDR_W-1:0],
//                        mem_wdata[31:0], mem_ack, mem_rdata[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : RV32I MEM-stage load/store controller. Aligns store data and
//               byte enables to the word address, issues one request per
//               access over a req/ack handshake, stalls the pipeline while the
//               access is outstanding, and extends the returned load word.
//               Also counts completed accesses and stall cycles.
// Ports       : clk, rst_n (sync, active-low)
//               load_type_MEM[2:0], cache_write_en_MEM[3:0], addr_MEM,
//               store_data_MEM[31:0], bubbleM            - pipeline inputs
//               bus (mem_access_ctrl_if.master)           - memory handshake
//               stall_mem, misaligned, load_data_MEM[31:0] - pipeline outputs
//               access_cnt[31:0], stall_cnt[31:0]          - perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [2:0]        load_type_MEM,
    input  wire logic [3:0]        cache_write_en_MEM,
    input  wire logic [ADDR_W-1:0] addr_MEM,
    input  wire logic [31:0]       store_data_MEM,
    input  wire logic              bubbleM,
    mem_access_ctrl_if.master      bus,
    output logic                   stall_mem,
    output logic                   misaligned,
    output logic [31:0]            load_data_MEM,
    output logic [31:0]            access_cnt,
    output logic [31:0]            stall_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] c_LT_LB  = 3'd1;
    localparam logic [2:0] c_LT_LH  = 3'd2;
    localparam logic [2:0] c_LT_LW  = 3'd3;
    localparam logic [2:0] c_LT_LBU = 3'd4;
    localparam logic [2:0] c_LT_LHU = 3'd5;

    logic [1:0]  r_state;
    logic [31:0] r_rdata_q;
    logic [1:0]  r_off_q;
    logic [31:0] r_access_cnt;
    logic [31:0] r_stall_cnt;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic [1:0]  w_off;
    logic [6:0]  w_be7;
    logic [31:0] w_wdata;
    logic        w_mis_raw;
    logic        w_misaligned;
    logic        w_stall;
    logic [31:0] w_rshift;
    logic [15:0] w_half;

    // ------------------------------------------------------------------
    // Access decode and alignment
    // ------------------------------------------------------------------
    assign w_is_load  = (load_type_MEM >= c_LT_LB) && (load_type_MEM <= c_LT_LHU);
    assign w_is_store = (cache_write_en_MEM != 4'b0000) && !w_is_load;
    assign w_access   = w_is_load || w_is_store;
    assign w_off      = addr_MEM[1:0];

    // Enables are shifted 7 bits wide so bytes pushed past lane 3 remain
    // visible for the misalignment check instead of being lost.
    assign w_be7   = {3'b000, cache_write_en_MEM} << w_off;
    assign w_wdata = store_data_MEM << {w_off, 3'b000};

    always_comb begin
        w_mis_raw = 1'b0;
        if (w_is_store) begin
            w_mis_raw = (w_be7[6:4] != 3'b000);
        end else begin
            case (load_type_MEM)
                c_LT_LH, c_LT_LHU: w_mis_raw = (w_off == 2'd3);
                c_LT_LW:           w_mis_raw = (w_off != 2'd0);
                default:           w_mis_raw = 1'b0;
            endcase
        end
    end

    assign w_misaligned = (r_state == S_IDLE) && w_access && w_mis_raw;
    assign w_stall      = ((r_state == S_IDLE) && w_access && !w_mis_raw) ||
                          (r_state == S_BUSY);

    assign misaligned = w_misaligned;
    assign stall_mem  = w_stall;
    assign access_cnt = r_access_cnt;
    assign stall_cnt  = r_stall_cnt;

    // ------------------------------------------------------------------
    // Load extension from the captured word and offset
    // ------------------------------------------------------------------
    assign w_rshift = r_rdata_q >> {r_off_q, 3'b000};
    assign w_half   = r_off_q[1] ? r_rdata_q[31:16] : r_rdata_q[15:0];

    always_comb begin
        load_data_MEM = 32'd0;
        // A misaligned instruction never reached memory, so any captured
        // word belongs to an older access and must not leak through.
        if (!w_misaligned) begin
            case (load_type_MEM)
                c_LT_LB:  load_data_MEM = {{24{w_rshift[7]}}, w_rshift[7:0]};
                c_LT_LBU: load_data_MEM = {24'd0, w_rshift[7:0]};
                c_LT_LH:  load_data_MEM = {{16{w_half[15]}}, w_half};
                c_LT_LHU: load_data_MEM = {16'd0, w_half};
                c_LT_LW:  load_data_MEM = r_rdata_q;
                default:  load_data_MEM = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM, request registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            r_rdata_q     <= 32'd0;
            r_off_q       <= 2'd0;
            r_access_cnt  <= 32'd0;
            r_stall_cnt   <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    // A stray ack here belongs to an abandoned request.
                    if (w_access && !w_mis_raw) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= w_is_store;
                        bus.mem_be    <= w_be7[3:0];
                        bus.mem_addr  <= {addr_MEM[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= w_wdata;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack) begin
                        bus.mem_req  <= 1'b0;
                        // The issued direction is authoritative for whether
                        // this access returns data.
                        if (!bus.mem_we) begin
                            r_rdata_q <= bus.mem_rdata;
                            r_off_q   <= w_off;
                        end
                        r_access_cnt <= r_access_cnt + 32'd1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Holding here rather than in IDLE prevents the held
                    // instruction from being issued a second time.
                    if (!bubbleM) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage controller of the RV32I pipeline, directly downstream of the ID/EX and EX/MEM control segment registers. It consumes the `load_type` and `cache_write_en` control fields carried down the pipeline, aligns store bytes and masks to the word address, and issues one request per load/store to a variable-latency data memory over a req/ack handshake. While the access is outstanding it stalls the pipeline, then sign- or zero-extends the returned load word for write-back. It also keeps two performance counters.

## Interface
- `ADDR_W`, default 32: width of the byte address.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `load_type_MEM`  in  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6–7 are treated as none.
- `cache_write_en_MEM`  in  4  unshifted store byte mask: 0000 none, 0001 SB, 0011 SH, 1111 SW.
- `addr_MEM`  in  ADDR_W  byte address, taken from the ALU result.
- `store_data_MEM`  in  32  unshifted rs2 value.
- `bubbleM`  in  1  hazard unit holds the MEM stage this cycle.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = write.
- `mem_be`  out  4  aligned byte enables.
- `mem_addr`  out  ADDR_W  word address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata`  out  32  aligned store data.
- `mem_ack`  in  1  memory completion; one-cycle pulse.
- `mem_rdata`  in  32  read word; valid only in the cycle `mem_ack` is high.
- `stall_mem`  out  1  request to the hazard unit to freeze IF..MEM.
- `misaligned`  out  1  misaligned access detected this cycle.
- `load_data_MEM`  out  32  extended load result.
- `access_cnt`  out  32  number of completed memory accesses.
- `stall_cnt`  out  32  number of cycles with `stall_mem` high.

## Operation
- **Access detection.** `is_load` = `load_type` in 1..5. `is_store` = `cache_write_en != 0` and not `is_load`. `access` = `is_load | is_store`.
- **Alignment.** `off = addr[1:0]`.
  - `be = cache_write_en << off`, computed 7 bits wide.
  - `wdata = store_data << (8*off)`, truncated to 32 bits.
  - A store is misaligned if `be[6:4] != 0`.
  - LH/LHU are misaligned if `off == 3`. LW is misaligned if `off != 0`.
- **Misaligned access.** `misaligned` is combinational: it is high in IDLE whenever the current access is misaligned. No request is issued, no stall is raised, and `load_data_MEM` returns 0 for that instruction.
- **FSM states.** IDLE, BUSY, DONE.
- **IDLE.** On an aligned access:
  - register `mem_req=1`, `mem_we=is_store`, `mem_be`, `mem_addr`, `mem_wdata`;
  - go to BUSY.
  - Otherwise stay in IDLE. A `mem_ack` arriving in IDLE is ignored.
- **BUSY.** `mem_req` and all request fields are held stable. On `mem_ack`:
  - clear `mem_req`;
  - if the access is a load, capture `mem_rdata` into `rdata_q` and `off` into `off_q`;
  - increment `access_cnt`;
  - go to DONE.
- **DONE.** Go to IDLE when `bubbleM == 0`; otherwise stay in DONE. Requests are never re-issued in DONE, so the same instruction is not accessed twice.
- **stall_mem.** Combinational: `(IDLE & access & !misaligned) | BUSY`. It is low in DONE.
- **stall_cnt.** Increments on every cycle in which `stall_mem == 1`.
- **load_data_MEM.** Combinational from `rdata_q`, `off_q` and the current `load_type`:
  - LB: sign-extend byte `off_q`.
  - LBU: zero-extend byte `off_q`.
  - LH: sign-extend halfword `off_q[1]`.
  - LHU: zero-extend halfword `off_q[1]`.
  - LW: the full word.
  - Otherwise 0.
- **Counters.** Both are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- **Reset** (`rst_n == 0` at an edge):
  - state becomes IDLE;
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rdata_q`, `off_q`, `access_cnt` and `stall_cnt` all become 0.
  - A reset during BUSY abandons the request. A later `mem_ack` then arrives in IDLE and is ignored.
- **Handshake.**
  - `mem_req` rises on the edge after the access enters the MEM stage.
  - `mem_ack` is legal from the cycle after `mem_req` rises.
  - `mem_req` falls on the edge at which the ack is sampled.
- **Minimum latency** (ack on the first BUSY cycle), 3 cycles per access:
  - cycle 0: IDLE, stall;
  - cycle 1: BUSY, stall;
  - cycle 2: DONE, no stall, `load_data_MEM` valid;
  - the pipeline advances at the end of cycle 2.
  - N wait cycles add N stall cycles.
- **Stall while in BUSY.** `bubbleM` high during BUSY has no effect on the handshake.
- **Back-to-back accesses.** The next access starts from IDLE on the cycle after DONE exits.

## Test plan
- **LB**: addr=0x1003, load_type=1, ack on the first BUSY cycle with rdata=0x80FF_0000 → `mem_req` is high for exactly 1 cycle with `mem_addr`=0x1000; `stall_mem` is high for 2 cycles; `load_data_MEM`=0xFFFFFF80 in DONE; `access_cnt`=1; `stall_cnt`=2.
- **SH**: addr=0x2002, cache_write_en=0011, store_data=0x0000ABCD, ack after 3 wait cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD0000, all held stable for 4 cycles; `stall_mem` is high for 5 cycles.
- **Misaligned LW**: addr=0x3001 → `misaligned`=1, `mem_req` stays 0, `stall_mem`=0, `load_data_MEM`=0, counters unchanged. The same check with SW at offset 2 gives the same response.
- **Held in DONE**: LHU at addr=0x4002, rdata=0x8001_0000, with `bubbleM`=1 for 2 cycles in DONE → FSM stays in DONE with `load_data_MEM`=0x00008001 stable; there is no second request.
- **Reset mid-access**: `rst_n`=0 during BUSY → the next cycle shows IDLE, `mem_req`=0 and counters 0; a stale `mem_ack` 2 cycles later causes no state change.
- **Counter wrap**: preset `access_cnt` to 0xFFFFFFFF (via a hierarchical force), complete one access → `access_cnt`=0.
